// File: rtl/mem_io_responder.sv
// Memory-side responder for the byte-serial memory bus: byte RAM plus an IO window
// (TX/RX FIFOs, status, halt). Read data returns one cycle after the request.
module mem_io_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int RAM_ADDR_BITS   = 17,
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int FULL_MARGIN     = 2
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_rdy,
  input  logic [ADDR_WIDTH-1:0] in_mem_addr,
  input  logic [7:0]            in_mem_data,
  input  logic                  in_mem_wr_signal,
  output logic [7:0]            out_mem_data,
  output logic                  out_io_buffer_full,
  output logic [7:0]            out_tx_data,
  output logic                  out_tx_valid,
  input  logic                  in_tx_ready,
  input  logic [7:0]            in_rx_data,
  input  logic                  in_rx_valid,
  output logic                  out_rx_ready,
  output logic                  out_halt,
  output logic [7:0]            out_halt_code,
  output logic                  out_tx_overflow
);
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(FULL_MARGIN);

  logic [7:0] ram    [0:(1<<RAM_ADDR_BITS)-1];
  logic [7:0] tx_mem [0:DEPTH-1];
  logic [7:0] rx_mem [0:DEPTH-1];

  logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, tx_free_d;
  logic [7:0]    mem_data_q, mem_data_d, halt_code_q, halt_code_d;
  logic          io_full_q, io_full_d, halt_q, halt_d, overflow_q, overflow_d;

  logic                     is_io, bus_rd, bus_wr, off0, off4;
  logic                     tx_full, tx_nonempty, rx_full, rx_nonempty;
  logic                     tx_req, tx_push, tx_pop, tx_drop, rx_push, rx_pop;
  logic                     ram_we, halt_we;
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  logic                     unused_addr;

  // Upper address bits only matter through the [17:16] IO decode
  assign unused_addr = ^in_mem_addr;
  assign ram_idx     = in_mem_addr[RAM_ADDR_BITS-1:0];
  assign is_io       = (in_mem_addr[17:16] == 2'b11);
  assign off0        = (in_mem_addr[2:0] == 3'd0);
  assign off4        = (in_mem_addr[2:0] == 3'd4);
  assign bus_wr      = in_rdy & in_mem_wr_signal;
  assign bus_rd      = in_rdy & ~in_mem_wr_signal;

  assign tx_full     = (tx_cnt_q == DEPTH_C);
  assign tx_nonempty = (tx_cnt_q != '0);
  assign rx_full     = (rx_cnt_q == DEPTH_C);
  assign rx_nonempty = (rx_cnt_q != '0);

  // A write into a full TX FIFO is still accepted when the host pops that same cycle
  assign tx_pop  = tx_nonempty & in_tx_ready;
  assign tx_req  = bus_wr & is_io & off0;
  assign tx_push = tx_req & (~tx_full | tx_pop);
  assign tx_drop = tx_req & tx_full & ~tx_pop;
  assign rx_push = in_rx_valid & ~rx_full;
  assign rx_pop  = bus_rd & is_io & off0 & rx_nonempty;
  assign ram_we  = bus_wr & ~is_io;
  assign halt_we = bus_wr & is_io & off4;

  always_comb begin
    tx_wptr_d   = tx_wptr_q + PW'(tx_push);
    tx_rptr_d   = tx_rptr_q + PW'(tx_pop);
    tx_cnt_d    = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_wptr_d   = rx_wptr_q + PW'(rx_push);
    rx_rptr_d   = rx_rptr_q + PW'(rx_pop);
    rx_cnt_d    = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    tx_free_d   = DEPTH_C - tx_cnt_d;
    io_full_d   = (tx_free_d <= MARGIN_C);
    overflow_d  = overflow_q | tx_drop;
    halt_d      = halt_q | halt_we;
    halt_code_d = halt_we ? in_mem_data : halt_code_q;
    mem_data_d  = mem_data_q;
    if (in_rdy) begin
      mem_data_d = 8'h00;
      if (!is_io) begin
        mem_data_d = ram[ram_idx];
      end else if (!in_mem_wr_signal) begin
        if (off0 && rx_nonempty) mem_data_d = rx_mem[rx_rptr_q];
        else if (off4)           mem_data_d = {6'b0, tx_full, rx_nonempty};
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      tx_cnt_q    <= '0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      rx_cnt_q    <= '0;
      mem_data_q  <= 8'h00;
      io_full_q   <= 1'b0;
      overflow_q  <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= 8'h00;
    end else begin
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      rx_cnt_q    <= rx_cnt_d;
      mem_data_q  <= mem_data_d;
      io_full_q   <= io_full_d;
      overflow_q  <= overflow_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
    end
  end

  // Storage arrays carry no reset; only pointers and counts define validity
  always_ff @(posedge in_clk) begin
    if (ram_we)  ram[ram_idx]       <= in_mem_data;
    if (tx_push) tx_mem[tx_wptr_q]  <= in_mem_data;
    if (rx_push) rx_mem[rx_wptr_q]  <= in_rx_data;
  end

  assign out_mem_data       = mem_data_q;
  assign out_io_buffer_full = io_full_q;
  assign out_tx_data        = tx_mem[tx_rptr_q];
  assign out_tx_valid       = tx_nonempty;
  assign out_rx_ready       = ~rx_full;
  assign out_halt           = halt_q;
  assign out_halt_code      = halt_code_q;
  assign out_tx_overflow    = overflow_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed steps plus randomized traffic, checked
// against a queue/associative-array reference model.
module tb_mem_io_responder;
  logic        clk = 1'b0;
  logic        rst_n, rdy, wr, tx_ready, rx_valid;
  logic [31:0] mem_addr;
  logic [7:0]  wdata, rx_data;
  logic [7:0]  out_mem_data, out_tx_data, out_halt_code;
  logic        out_io_buffer_full, out_tx_valid, out_rx_ready, out_halt, out_tx_overflow;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_ram [int];
  logic [7:0] m_tx [$];
  logic [7:0] m_rx [$];
  bit         m_ovf, m_halt, m_full, exp_known;
  logic [7:0] m_code, exp_data;

  always #5 clk = ~clk;

  mem_io_responder dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_rdy(rdy),
    .in_mem_addr(mem_addr), .in_mem_data(wdata), .in_mem_wr_signal(wr),
    .out_mem_data(out_mem_data), .out_io_buffer_full(out_io_buffer_full),
    .out_tx_data(out_tx_data), .out_tx_valid(out_tx_valid), .in_tx_ready(tx_ready),
    .in_rx_data(rx_data), .in_rx_valid(rx_valid), .out_rx_ready(out_rx_ready),
    .out_halt(out_halt), .out_halt_code(out_halt_code), .out_tx_overflow(out_tx_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_ovf = 0; m_halt = 0; m_full = 0; m_code = 8'h00;
    exp_data = 8'h00; exp_known = 1;
  endtask

  task automatic check_outputs();
    if (exp_known) chk("mem_data", out_mem_data, exp_data);
    chk("io_full", out_io_buffer_full, m_full);
    chk("tx_valid", out_tx_valid, m_tx.size() > 0);
    if (m_tx.size() > 0) chk("tx_data", out_tx_data, m_tx[0]);
    chk("rx_ready", out_rx_ready, m_rx.size() < 8);
    chk("halt", out_halt, m_halt);
    chk("halt_code", out_halt_code, m_code);
    chk("tx_overflow", out_tx_overflow, m_ovf);
  endtask

  // Apply current inputs for one edge, advance the model, then check.
  task automatic cycle();
    bit tx_pop_now, tx_push_now, rx_push_now, is_io;
    logic [2:0] off;
    int ra;
    tx_pop_now  = (m_tx.size() > 0) && tx_ready;
    rx_push_now = rx_valid && (m_rx.size() < 8);
    tx_push_now = 0;
    is_io = (mem_addr[17:16] == 2'b11);
    off   = mem_addr[2:0];
    ra    = int'(mem_addr[16:0]);
    if (rdy) begin
      if (!is_io) begin
        exp_known = m_ram.exists(ra) != 0;
        if (exp_known) exp_data = m_ram[ra];
        if (wr) m_ram[ra] = wdata;
      end else if (wr) begin
        exp_known = 0;
        if (off == 3'd0) begin
          if (m_tx.size() < 8 || tx_pop_now) tx_push_now = 1;
          else m_ovf = 1;
        end else if (off == 3'd4) begin
          m_halt = 1; m_code = wdata;
        end
      end else begin
        exp_known = 1; exp_data = 8'h00;
        if (off == 3'd0 && m_rx.size() > 0) exp_data = m_rx.pop_front();
        else if (off == 3'd4) exp_data = {6'b0, m_tx.size() == 8, m_rx.size() > 0};
      end
    end
    if (tx_pop_now)  void'(m_tx.pop_front());
    if (tx_push_now) m_tx.push_back(wdata);
    if (rx_push_now) m_rx.push_back(rx_data);
    m_full = (8 - m_tx.size()) <= 2;
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic req(input bit r, input logic [31:0] a, input logic [7:0] d, input bit w);
    rdy = r; mem_addr = a; wdata = d; wr = w;
    cycle();
  endtask

  initial begin
    logic [7:0]  v;
    logic [31:0] a;
    rst_n = 0; rdy = 0; wr = 0; mem_addr = 32'h100; wdata = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    model_reset();
    #12;
    check_outputs();
    #8 rst_n = 1;
    @(posedge clk); #1;

    // RAM write then streaming read-back
    for (int i = 0; i < 4; i++) begin
      v = 8'(8'h11 * (i + 1));
      req(1, 32'h100 + 32'(i), v, 1);
    end
    for (int i = 0; i < 4; i++) begin
      v = 8'(8'h11 * (i + 1));
      req(1, 32'h100 + 32'(i), 8'h00, 0);
      chk("ram_stream", out_mem_data, v);
    end

    // TX fill with host stalled, then drain
    tx_ready = 0;
    for (int i = 0; i < 9; i++) begin
      req(1, 32'h30000, 8'(8'h41 + i), 1);
      if (i == 4) chk("tx_full_after5", out_io_buffer_full, 1'b0);
      if (i == 5) chk("tx_full_after6", out_io_buffer_full, 1'b1);
    end
    chk("tx_overflow_set", out_tx_overflow, 1'b1);
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("tx_stream", out_tx_data, 8'(8'h41 + i));
      req(1, 32'h100, 8'h00, 0);
    end
    chk("tx_drained", out_tx_valid, 1'b0);

    // RX path, including no bypass into an empty FIFO
    rx_valid = 1; rx_data = 8'h5A;
    req(1, 32'h30000, 8'h00, 0);
    chk("rx_no_bypass", out_mem_data, 8'h00);
    rx_data = 8'hA5;
    req(1, 32'h100, 8'h00, 0);
    rx_valid = 0;
    req(1, 32'h30004, 8'h00, 0);
    chk("rx_status", out_mem_data, 8'h01);
    req(1, 32'h30000, 8'h00, 0);
    chk("rx_pop1", out_mem_data, 8'h5A);
    req(1, 32'h30000, 8'h00, 0);
    chk("rx_pop2", out_mem_data, 8'hA5);
    req(1, 32'h30000, 8'h00, 0);
    chk("rx_empty", out_mem_data, 8'h00);
    req(1, 32'h30004, 8'h00, 0);
    chk("status_idle", out_mem_data, 8'h00);

    // Halt, sticky through traffic
    req(1, 32'h30004, 8'h03, 1);
    chk("halt_set", out_halt, 1'b1);
    chk("halt_code_set", out_halt_code, 8'h03);
    req(1, 32'h100, 8'h00, 0);
    req(0, 32'h30004, 8'h09, 1);
    chk("halt_code_held", out_halt_code, 8'h03);

    // Asynchronous reset with both FIFOs holding data
    tx_ready = 0;
    req(1, 32'h30000, 8'hC1, 1);
    rx_valid = 1; rx_data = 8'h77;
    req(1, 32'h30000, 8'hC2, 1);
    rx_valid = 0;
    req(1, 32'h100, 8'h00, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    #1 rst_n = 1;
    req(1, 32'h100, 8'h00, 0);
    chk("ram_survives_reset", out_mem_data, 8'h11);

    // Global ready low: no write, output holds
    req(0, 32'h101, 8'hEE, 1);
    chk("rdy_low_hold", out_mem_data, 8'h11);
    req(1, 32'h101, 8'h00, 0);
    chk("rdy_low_no_write", out_mem_data, 8'h22);

    // Simultaneous push and pop at count 7
    tx_ready = 0;
    for (int i = 0; i < 7; i++) req(1, 32'h30000, 8'(8'h61 + i), 1);
    tx_ready = 1;
    req(1, 32'h30000, 8'h77, 1);
    chk("sim_no_overflow", out_tx_overflow, 1'b0);
    chk("sim_full_flag", out_io_buffer_full, 1'b1);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) chk("sim_last_byte", out_tx_data, 8'h77);
      req(1, 32'h100, 8'h00, 0);
    end
    chk("sim_count7", out_tx_valid, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: a = 32'h100 + 32'($urandom_range(0, 15));
        3:       a = 32'h30000;
        4:       a = 32'h30004;
        5:       a = 32'h30000 | 32'($urandom_range(0, 7)) | (32'($urandom_range(0, 255)) << 24);
        default: a = 32'h40100 + 32'($urandom_range(0, 15));
      endcase
      tx_ready = ($urandom_range(0, 1) == 1);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      req($urandom_range(0, 7) != 0, a, 8'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
